// File: rtl/mem_deco_pkg.sv
// Shared types and sizing helpers for the banked dual-port memory decoder.
// The default geometry is 8-bit addresses over 4 banks.
package mem_deco_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_BANK_W = 2;
    localparam int NUM_BANKS  = 2 ** DEF_BANK_W;
    localparam int ROW_W      = DEF_ADDR_W - DEF_BANK_W;

    typedef logic [DEF_BANK_W-1:0] bank_idx_t;

    typedef enum logic {
        PRIO_A = 1'b0,
        PRIO_B = 1'b1
    } prio_e;

    function automatic int num_banks(input int bank_w);
        return 1 << bank_w;
    endfunction

endpackage

// File: rtl/mem_onehot_deco.sv
// Bank index to one-hot select decoder. When en is low the output is all zero,
// which downstream logic treats as the idle value.
module mem_onehot_deco
    import mem_deco_pkg::*;
#(
    parameter int BANK_W = 2
) (
    input  logic [BANK_W-1:0]            idx,
    input  logic                         en,
    output logic [num_banks(BANK_W)-1:0] sel
);

    always_comb begin
        sel = '0;
        if (en) begin
            sel[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_bank_arb_deco.sv
// Dual-port bank decoder with round-robin arbitration of same-bank write conflicts.
// Grants are combinational; selects, rows, write enables and the counter are registered.
module mem_bank_arb_deco
    import mem_deco_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int BANK_W = 2,
    parameter int CNT_W  = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         a_req,
    input  logic                         a_we,
    input  logic [ADDR_W-1:0]            a_addr,
    input  logic                         b_req,
    input  logic                         b_we,
    input  logic [ADDR_W-1:0]            b_addr,
    output logic                         a_gnt,
    output logic                         b_gnt,
    output logic [num_banks(BANK_W)-1:0] a_bank_sel,
    output logic [num_banks(BANK_W)-1:0] b_bank_sel,
    output logic [ADDR_W-BANK_W-1:0]     a_row,
    output logic [ADDR_W-BANK_W-1:0]     b_row,
    output logic                         a_we_q,
    output logic                         b_we_q,
    output logic                         prio_b,
    output logic [CNT_W-1:0]             conflict_cnt
);

    localparam int N_BANKS  = num_banks(BANK_W);
    localparam int ROW_BITS = ADDR_W - BANK_W;

    logic [BANK_W-1:0]   a_bank, b_bank;
    logic                conflict;
    logic [N_BANKS-1:0]  a_sel_d, b_sel_d;
    logic [N_BANKS-1:0]  a_sel_q, b_sel_q;
    logic [ROW_BITS-1:0] a_row_d, b_row_d;
    logic [ROW_BITS-1:0] a_row_q, b_row_q;
    logic                a_we_d, b_we_d;
    logic                a_we_r, b_we_r;
    prio_e               prio_d, prio_q;
    logic [CNT_W-1:0]    cnt_d, cnt_q;

    assign a_bank = a_addr[ADDR_W-1 -: BANK_W];
    assign b_bank = b_addr[ADDR_W-1 -: BANK_W];

    // Same-bank read/read is harmless; only a write on either side collides.
    assign conflict = a_req & b_req & (a_bank == b_bank) & (a_we | b_we);

    assign a_gnt = a_req & (~conflict | (prio_q == PRIO_A));
    assign b_gnt = b_req & (~conflict | (prio_q == PRIO_B));

    mem_onehot_deco #(.BANK_W(BANK_W)) u_deco_a (
        .idx (a_bank),
        .en  (a_gnt),
        .sel (a_sel_d)
    );

    mem_onehot_deco #(.BANK_W(BANK_W)) u_deco_b (
        .idx (b_bank),
        .en  (b_gnt),
        .sel (b_sel_d)
    );

    always_comb begin
        a_row_d = a_gnt ? a_addr[ROW_BITS-1:0] : a_row_q;
        b_row_d = b_gnt ? b_addr[ROW_BITS-1:0] : b_row_q;
        a_we_d  = a_gnt & a_we;
        b_we_d  = b_gnt & b_we;
        prio_d  = prio_q;
        if (conflict) begin
            prio_d = (prio_q == PRIO_A) ? PRIO_B : PRIO_A;
        end
        cnt_d = cnt_q;
        if (conflict && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sel_q <= '0;
            b_sel_q <= '0;
            a_row_q <= '0;
            b_row_q <= '0;
            a_we_r  <= 1'b0;
            b_we_r  <= 1'b0;
            prio_q  <= PRIO_A;
            cnt_q   <= '0;
        end else begin
            a_sel_q <= a_sel_d;
            b_sel_q <= b_sel_d;
            a_row_q <= a_row_d;
            b_row_q <= b_row_d;
            a_we_r  <= a_we_d;
            b_we_r  <= b_we_d;
            prio_q  <= prio_d;
            cnt_q   <= cnt_d;
        end
    end

    assign a_bank_sel   = a_sel_q;
    assign b_bank_sel   = b_sel_q;
    assign a_row        = a_row_q;
    assign b_row        = b_row_q;
    assign a_we_q       = a_we_r;
    assign b_we_q       = b_we_r;
    assign prio_b       = (prio_q == PRIO_B);
    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_mem_bank_arb_deco.sv
// Bench for mem_bank_arb_deco: vector table plus scoreboard of next-cycle outputs,
// with a second instance at CNT_W=2 to exercise counter saturation.
module tb_mem_bank_arb_deco;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [7:0] a_addr = '0, b_addr = '0;

    logic       a_gnt, b_gnt, a_we_q, b_we_q, prio_b;
    logic [3:0] a_bank_sel, b_bank_sel;
    logic [5:0] a_row, b_row;
    logic [7:0] conflict_cnt;

    logic       a_gnt2, b_gnt2, a_we_q2, b_we_q2, prio_b2;
    logic [3:0] a_bank_sel2, b_bank_sel2;
    logic [5:0] a_row2, b_row2;
    logic [1:0] conflict_cnt2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_bank_arb_deco #(.ADDR_W(8), .BANK_W(2), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr),
        .a_gnt(a_gnt), .b_gnt(b_gnt),
        .a_bank_sel(a_bank_sel), .b_bank_sel(b_bank_sel),
        .a_row(a_row), .b_row(b_row),
        .a_we_q(a_we_q), .b_we_q(b_we_q),
        .prio_b(prio_b), .conflict_cnt(conflict_cnt)
    );

    mem_bank_arb_deco #(.ADDR_W(8), .BANK_W(2), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr),
        .a_gnt(a_gnt2), .b_gnt(b_gnt2),
        .a_bank_sel(a_bank_sel2), .b_bank_sel(b_bank_sel2),
        .a_row(a_row2), .b_row(b_row2),
        .a_we_q(a_we_q2), .b_we_q(b_we_q2),
        .prio_b(prio_b2), .conflict_cnt(conflict_cnt2)
    );

    typedef struct {
        logic       ar, aw;
        logic [7:0] aa;
        logic       br, bw;
        logic [7:0] ba;
        logic       eag, ebg;
        logic [3:0] eas, ebs;
        logic [5:0] ear, ebr;
        logic       eaw, ebw, ep;
        logic [7:0] ec;
    } vec_t;

    typedef struct {
        string      tag;
        logic [3:0] eas, ebs;
        logic [5:0] ear, ebr;
        logic       eaw, ebw, ep;
        logic [7:0] ec;
        logic [1:0] ec2;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[11];
    vec_t pre[2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step(input vec_t v, input string tag);
        exp_t e;
        @(negedge clk);
        a_req = v.ar; a_we = v.aw; a_addr = v.aa;
        b_req = v.br; b_we = v.bw; b_addr = v.ba;
        e.tag = tag;
        e.eas = v.eas; e.ebs = v.ebs; e.ear = v.ear; e.ebr = v.ebr;
        e.eaw = v.eaw; e.ebw = v.ebw; e.ep = v.ep; e.ec = v.ec;
        e.ec2 = (v.ec > 8'd3) ? 2'd3 : v.ec[1:0];
        sb.push_back(e);
        #1;
        chk({tag, ".a_gnt"}, a_gnt, v.eag);
        chk({tag, ".b_gnt"}, b_gnt, v.ebg);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            chk({e.tag, ".a_sel"}, a_bank_sel, e.eas);
            chk({e.tag, ".b_sel"}, b_bank_sel, e.ebs);
            chk({e.tag, ".a_row"}, a_row, e.ear);
            chk({e.tag, ".b_row"}, b_row, e.ebr);
            chk({e.tag, ".a_we_q"}, a_we_q, e.eaw);
            chk({e.tag, ".b_we_q"}, b_we_q, e.ebw);
            chk({e.tag, ".prio_b"}, prio_b, e.ep);
            chk({e.tag, ".cnt"}, conflict_cnt, e.ec);
            chk({e.tag, ".cnt2"}, conflict_cnt2, e.ec2);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ".a_sel"}, a_bank_sel, 0);
        chk({tag, ".b_sel"}, b_bank_sel, 0);
        chk({tag, ".a_row"}, a_row, 0);
        chk({tag, ".b_row"}, b_row, 0);
        chk({tag, ".we_q"}, {a_we_q, b_we_q}, 0);
        chk({tag, ".prio_b"}, prio_b, 0);
        chk({tag, ".cnt"}, conflict_cnt, 0);
        chk({tag, ".cnt2"}, conflict_cnt2, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //          ar aw aa     br bw ba     eag ebg eas      ebs      ear    ebr    eaw ebw ep ec
        tbl[0]  = '{0, 0, 8'h00, 0, 0, 8'h00, 0,  0,  4'b0000, 4'b0000, 6'h00, 6'h00, 0,  0,  0, 8'd0};
        tbl[1]  = '{1, 0, 8'h05, 1, 1, 8'hC3, 1,  1,  4'b0001, 4'b1000, 6'h05, 6'h03, 0,  1,  0, 8'd0};
        tbl[2]  = '{1, 1, 8'h41, 1, 1, 8'h47, 1,  0,  4'b0010, 4'b0000, 6'h01, 6'h03, 1,  0,  1, 8'd1};
        tbl[3]  = '{0, 0, 8'h00, 1, 1, 8'h47, 0,  1,  4'b0000, 4'b0010, 6'h01, 6'h07, 0,  1,  1, 8'd1};
        tbl[4]  = '{1, 0, 8'h80, 1, 0, 8'h85, 1,  1,  4'b0100, 4'b0100, 6'h00, 6'h05, 0,  0,  1, 8'd1};
        tbl[5]  = '{0, 0, 8'h00, 0, 0, 8'h00, 0,  0,  4'b0000, 4'b0000, 6'h00, 6'h05, 0,  0,  1, 8'd1};
        tbl[6]  = '{1, 1, 8'hF0, 1, 0, 8'hFF, 0,  1,  4'b0000, 4'b1000, 6'h00, 6'h3F, 0,  0,  0, 8'd2};
        tbl[7]  = '{1, 1, 8'hF0, 0, 0, 8'h00, 1,  0,  4'b1000, 4'b0000, 6'h30, 6'h3F, 1,  0,  0, 8'd2};
        tbl[8]  = '{1, 1, 8'h12, 1, 1, 8'h7E, 1,  1,  4'b0001, 4'b0010, 6'h12, 6'h3E, 1,  1,  0, 8'd2};
        tbl[9]  = '{1, 1, 8'h25, 1, 1, 8'hA9, 1,  1,  4'b0001, 4'b0100, 6'h25, 6'h29, 1,  1,  0, 8'd2};
        tbl[10] = '{1, 0, 8'h33, 0, 1, 8'h01, 1,  0,  4'b0001, 4'b0000, 6'h33, 6'h29, 0,  0,  0, 8'd2};
        pre[0]  = '{1, 1, 8'h41, 1, 1, 8'h42, 1,  0,  4'b0010, 4'b0000, 6'h01, 6'h29, 1,  0,  1, 8'd3};
        pre[1]  = '{1, 0, 8'h80, 0, 0, 8'h00, 1,  0,  4'b0100, 4'b0000, 6'h00, 6'h29, 0,  0,  1, 8'd3};

        #2 rst = 1'b1;
        #1 chk_reset_state("reset0");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            step(tbl[i], $sformatf("vec%0d", i));
        end

        // Build up selects, priority and count, then reset between edges.
        step(pre[0], "pre0");
        step(pre[1], "pre1");
        #2 rst = 1'b1;
        #1 chk_reset_state("async_rst");
        @(negedge clk);
        a_req = 1'b0; b_req = 1'b0; a_we = 1'b0; b_we = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Sustained same-bank write conflict: grants alternate, counters climb.
        for (int i = 0; i < 5; i++) begin
            vec_t v;
            v = '{1, 1, 8'h41, 1, 1, 8'h47, 0, 0, 4'b0000, 4'b0000, 6'h01, 6'h00, 0, 0, 0, 8'd0};
            v.eag = (i % 2 == 0);
            v.ebg = (i % 2 == 1);
            v.eas = v.eag ? 4'b0010 : 4'b0000;
            v.ebs = v.ebg ? 4'b0010 : 4'b0000;
            v.ebr = (i >= 1) ? 6'h07 : 6'h00;
            v.eaw = v.eag;
            v.ebw = v.ebg;
            v.ep  = (i % 2 == 0);
            v.ec  = 8'(i + 1);
            step(v, $sformatf("conf%0d", i));
        end

        for (int i = 0; i < 255; i++) begin
            @(negedge clk);
        end
        #1;
        chk("sat.cnt8", conflict_cnt, 8'hFF);
        chk("sat.cnt2", conflict_cnt2, 2'd3);

        @(negedge clk);
        a_req = 1'b0; b_req = 1'b0;
        @(posedge clk);
        #1;
        chk("sat_hold.cnt8", conflict_cnt, 8'hFF);
        chk("sat_hold.a_sel", a_bank_sel, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
